// File: rtl/bus_ctrl_8288.sv
// rtl/bus_ctrl_8288.sv - 8288 bus controller: status decode, ALE/DEN/DT_R and bus commands
// Define BUS_CTRL_ADV_WRITE_EN to advance write commands to T2.
module bus_ctrl_8288 #(
   parameter int MAX_WAIT = 0,
   parameter int WAIT_W   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] s_n,
   input  logic       ready,
   input  logic       cen,
   output logic       ale,
   output logic       den,
   output logic       dt_r,
   output logic       mrdc_n,
   output logic       mwtc_n,
   output logic       iorc_n,
   output logic       iowc_n,
   output logic       inta_n,
   output logic       timeout
);
   typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;

   localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

   state_t            state, state_nx;
   logic [2:0]        cyc_type, type_nx;
   logic [WAIT_W-1:0] wait_cnt, cnt_nx;
   logic              prev_passive;
   logic              timeout_nx;
   logic              ale_nx, den_nx, dt_r_nx;
   logic              mrdc_nx, mwtc_nx, iorc_nx, iowc_nx, inta_nx;
   logic              is_write, rd_phase, wr_phase;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         cyc_type     <= 3'b111;
         wait_cnt     <= '0;
         prev_passive <= 1'b0;
         ale          <= 1'b0;
         den          <= 1'b0;
         dt_r         <= 1'b1;
         mrdc_n       <= 1'b1;
         mwtc_n       <= 1'b1;
         iorc_n       <= 1'b1;
         iowc_n       <= 1'b1;
         inta_n       <= 1'b1;
         timeout      <= 1'b0;
      end else begin
         state        <= state_nx;
         cyc_type     <= type_nx;
         wait_cnt     <= cnt_nx;
         prev_passive <= (s_n == 3'b111);
         ale          <= ale_nx;
         den          <= den_nx;
         dt_r         <= dt_r_nx;
         mrdc_n       <= mrdc_nx;
         mwtc_n       <= mwtc_nx;
         iorc_n       <= iorc_nx;
         iowc_n       <= iowc_nx;
         inta_n       <= inta_nx;
         timeout      <= timeout_nx;
      end
   end

   // A cycle only starts on an active status that follows a passive sample.
   always_comb begin
      state_nx   = state;
      type_nx    = cyc_type;
      cnt_nx     = wait_cnt;
      timeout_nx = 1'b0;
      case (state)
         IDLE: begin
            if (prev_passive && s_n != 3'b111 && s_n != 3'b011) begin
               state_nx = T1;
               type_nx  = s_n;
            end
         end
         T1: state_nx = T2;
         T2: begin
            state_nx = T3;
            cnt_nx   = '0;
         end
         T3: begin
            if (ready) begin
               state_nx = T4;
            end else if (MAX_WAIT != 0 && wait_cnt == MAX_W) begin
               state_nx   = T4;
               timeout_nx = 1'b1;
            end else if (wait_cnt != '1) begin
               cnt_nx = wait_cnt + 1'b1;
            end
         end
         T4:      state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are decoded from the upcoming state so that they register in step with it.
   always_comb begin
      is_write = (type_nx == 3'b010) || (type_nx == 3'b110);
      rd_phase = (state_nx == T2) || (state_nx == T3);
`ifdef BUS_CTRL_ADV_WRITE_EN
      wr_phase = (state_nx == T2) || (state_nx == T3);
`else
      wr_phase = (state_nx == T3);
`endif
      ale_nx  = (state_nx == T1);
      den_nx  = rd_phase;
      dt_r_nx = (state_nx == IDLE) ? 1'b1 : is_write;
      mrdc_nx = !(cen && rd_phase && type_nx[2:1] == 2'b10);
      mwtc_nx = !(cen && wr_phase && type_nx == 3'b110);
      iorc_nx = !(cen && rd_phase && type_nx == 3'b001);
      iowc_nx = !(cen && wr_phase && type_nx == 3'b010);
      inta_nx = !(cen && rd_phase && type_nx == 3'b000);
   end
endmodule

// File: tb/tb_bus_ctrl_8288.sv
// tb/tb_bus_ctrl_8288.sv - scoreboard bench for bus_ctrl_8288 with a transaction-level reference
`timescale 1ns/1ps
module tb_bus_ctrl_8288;
   localparam int MAXW = 3;
`ifdef BUS_CTRL_ADV_WRITE_EN
   localparam bit ADV = 1'b1;
`else
   localparam bit ADV = 1'b0;
`endif
   // {ale, den, dt_r, mrdc_n, mwtc_n, iorc_n, iowc_n, inta_n, timeout}
   localparam logic [8:0] IDLE_V = 9'b001_11111_0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] s_n = 3'b111;
   logic       ready = 1'b1;
   logic       cen = 1'b1;
   logic       ale, den, dt_r, mrdc_n, mwtc_n, iorc_n, iowc_n, inta_n, timeout;

   logic [8:0] exp_q[$];
   string      tag_q[$];
   int         errors = 0;
   int         checks = 0;
   logic [2:0] last_sn = 3'b111;

   always #5 clk = ~clk;

   bus_ctrl_8288 #(.MAX_WAIT(MAXW), .WAIT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .s_n(s_n), .ready(ready), .cen(cen),
      .ale(ale), .den(den), .dt_r(dt_r), .mrdc_n(mrdc_n), .mwtc_n(mwtc_n),
      .iorc_n(iorc_n), .iowc_n(iowc_n), .inta_n(inta_n), .timeout(timeout)
   );

   // Monitor: every edge preceded by a driven step has exactly one expected vector.
   initial begin
      logic [8:0] got, e;
      string      tag;
      forever begin
         @(posedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            got = {ale, den, dt_r, mrdc_n, mwtc_n, iorc_n, iowc_n, inta_n, timeout};
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL %s: got %b expected %b", tag, got, e);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step(input logic [2:0] sn, input logic rdy, input logic c,
                       input logic rst, input logic [8:0] e, input string tag);
      @(negedge clk);
      s_n     = sn;
      ready   = rdy;
      cen     = c;
      rst_n   = rst;
      last_sn = sn;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   function automatic int cmd_idx(input logic [2:0] code);
      case (code)
         3'b000:  return 1;
         3'b001:  return 3;
         3'b010:  return 2;
         3'b110:  return 4;
         default: return 5;
      endcase
   endfunction

   function automatic logic pick_cen(input int mode);
      if (mode == 0) return 1'b0;
      if (mode == 1) return 1'b1;
      return 1'($urandom_range(0, 1));
   endfunction

   // Idle-time status that can never start a cycle.
   function automatic logic [2:0] rand_idle();
      logic [2:0] r;
      r = 3'($urandom_range(0, 7));
      if (last_sn == 3'b111 && r != 3'b111 && r != 3'b011) r = 3'b011;
      return r;
   endfunction

   function automatic logic [2:0] rsn();
      return 3'($urandom_range(0, 7));
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // One bus cycle: gap idle clocks ending on passive, then T1, T2, T3, w requested waits, T4.
   task automatic run_cycle(input logic [2:0] code, input int w, input int cmode, input int gap);
      bit         wr;
      bit         to;
      int         ci;
      int         tw;
      logic [8:0] e;
      logic       c;
      logic [2:0] sn;
      wr = (code == 3'b010) || (code == 3'b110);
      ci = cmd_idx(code);
      to = (MAXW != 0) && (w > MAXW);
      tw = to ? MAXW : w;
      for (int i = 0; i < gap; i++) begin
         sn = (i == gap - 1) ? 3'b111 : rand_idle();
         step(sn, rbit(), rbit(), 1'b1, IDLE_V, "idle");
      end
      e = IDLE_V; e[8] = 1'b1; e[6] = wr;
      step(code, rbit(), rbit(), 1'b1, e, "t1");
      c = pick_cen(cmode);
      e = IDLE_V; e[7] = 1'b1; e[6] = wr;
      if (!wr || ADV) e[ci] = !c;
      step(rsn(), rbit(), c, 1'b1, e, "t2");
      c = pick_cen(cmode);
      e = IDLE_V; e[7] = 1'b1; e[6] = wr; e[ci] = !c;
      step(rsn(), rbit(), c, 1'b1, e, "t3");
      for (int k = 0; k < tw; k++) begin
         c = pick_cen(cmode);
         e = IDLE_V; e[7] = 1'b1; e[6] = wr; e[ci] = !c;
         step(rsn(), 1'b0, c, 1'b1, e, "tw");
      end
      e = IDLE_V; e[6] = wr; e[0] = to;
      step(rsn(), to ? 1'b0 : 1'b1, rbit(), 1'b1, e, "t4");
   endtask

   initial begin
      logic [8:0] e;
      logic [2:0] codes[6];
      codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};

      step(3'b101, 1'b1, 1'b1, 1'b0, IDLE_V, "reset");
      step(3'b101, 1'b1, 1'b1, 1'b0, IDLE_V, "reset");
      repeat (3) step(3'b101, 1'b1, 1'b1, 1'b1, IDLE_V, "no_passive");
      step(3'b111, 1'b1, 1'b1, 1'b1, IDLE_V, "idle");
      step(3'b011, 1'b1, 1'b1, 1'b1, IDLE_V, "halt");
      step(3'b011, 1'b1, 1'b1, 1'b1, IDLE_V, "halt");

      run_cycle(3'b101, 0, 1, 1);
      run_cycle(3'b010, 2, 1, 2);
      run_cycle(3'b000, 1, 0, 1);
      run_cycle(3'b001, 6, 1, 1);
      run_cycle(3'b110, 3, 1, 1);

      // Reset during a wait state of a memory write
      step(3'b111, 1'b1, 1'b1, 1'b1, IDLE_V, "idle");
      e = IDLE_V; e[8] = 1'b1; e[6] = 1'b1;
      step(3'b110, 1'b1, 1'b1, 1'b1, e, "w_t1");
      e = IDLE_V; e[7] = 1'b1; e[6] = 1'b1; e[4] = !ADV;
      step(3'b110, 1'b1, 1'b1, 1'b1, e, "w_t2");
      e[4] = 1'b0;
      step(3'b110, 1'b1, 1'b1, 1'b1, e, "w_t3");
      step(3'b110, 1'b0, 1'b1, 1'b1, e, "w_tw");
      step(3'b110, 1'b0, 1'b1, 1'b0, IDLE_V, "rst_mid");
      step(3'b110, 1'b1, 1'b1, 1'b1, IDLE_V, "no_restart");
      step(3'b110, 1'b1, 1'b1, 1'b1, IDLE_V, "no_restart");

      for (int n = 0; n < 80; n++)
         run_cycle(codes[$urandom_range(0, 5)], int'($urandom_range(0, 5)), 2,
                   int'($urandom_range(1, 3)));

      step(3'b111, 1'b1, 1'b1, 1'b1, IDLE_V, "idle");
      step(3'b111, 1'b1, 1'b1, 1'b1, IDLE_V, "idle");
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
